// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision adder
// between NUM_REQ requesters, with a one-entry valid/ready output register.

// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Denormals are handled; any NaN input yields the canonical quiet NaN.
module fp_add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic        sx, sy, sub, rnd, found;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic [7:0]  ex, ey, d;
    logic [22:0] fx, fy;
    logic [26:0] xs, ys, full, mask, n;   // 24-bit significand + guard/round/sticky
    logic [27:0] sum;
    logic [9:0]  e, sh;
    logic [4:0]  lz;
    logic [24:0] mr;

    // Align, add/subtract, normalise, round, then pick special results
    always_comb begin
        y     = '0;
        found = 1'b0;
        lz    = 5'd27;
        sh    = '0;
        mask  = '0;
        nan_a = (&a[30:23]) && (|a[22:0]);
        nan_b = (&b[30:23]) && (|b[22:0]);
        inf_a = (&a[30:23]) && !(|a[22:0]);
        inf_b = (&b[30:23]) && !(|b[22:0]);
        // x is the operand with the larger magnitude, so the difference stays positive
        if (b[30:0] > a[30:0]) begin
            {sx, ex, fx} = b;
            {sy, ey, fy} = a;
        end else begin
            {sx, ex, fx} = a;
            {sy, ey, fy} = b;
        end
        sub  = sx ^ sy;
        // denormals use an effective exponent of 1 with no hidden bit
        d    = (ex == 8'd0 ? 8'd1 : ex) - (ey == 8'd0 ? 8'd1 : ey);
        xs   = {ex != 8'd0, fx, 3'b000};
        full = {ey != 8'd0, fy, 3'b000};
        if (d >= 8'd27) begin
            ys = {26'b0, |full};
        end else begin
            mask  = (27'd1 << d) - 27'd1;
            ys    = full >> d;
            ys[0] = ys[0] | (|(full & mask));
        end
        sum = sub ? ({1'b0, xs} - {1'b0, ys}) : ({1'b0, xs} + {1'b0, ys});
        e   = {2'b00, (ex == 8'd0 ? 8'd1 : ex)};
        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'd1;
        end else begin
            for (int i = 26; i >= 0; i--) begin
                if (!found && sum[i]) begin
                    lz    = 5'(26 - i);
                    found = 1'b1;
                end
            end
            // never shift below exponent 1; what remains is a denormal
            sh = ({5'b0, lz} > e - 10'd1) ? e - 10'd1 : {5'b0, lz};
            n  = sum[26:0] << sh;
            e  = e - sh;
        end
        rnd = n[2] & (n[1] | n[0] | n[3]);
        mr  = {1'b0, n[26:3]} + {24'b0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'd1;
        end
        if (nan_a || nan_b || (inf_a && inf_b && (a[31] ^ b[31])))
            y = 32'h7FC0_0000;
        else if (inf_a)
            y = a;
        else if (inf_b)
            y = b;
        else if (sum == 28'd0)
            y = {sx & sy, 31'b0};
        else if (e >= 10'd255)
            y = {sx, 8'hFF, 23'b0};
        else
            y = {sx, (mr[23] ? e[7:0] : 8'h00), mr[22:0]};
    end
endmodule

module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_operand_a,
    input  logic [32*NUM_REQ-1:0] req_operand_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_result,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           op_count
);
    typedef struct packed {
        logic [31:0]     result;
        logic [ID_W-1:0] id;
    } rsp_t;

    logic [ID_W-1:0]    rr_ptr, gnt_idx;
    logic               gnt_any, can_issue;
    logic [NUM_REQ-1:0] gnt;
    logic [31:0]        add_a, add_b, add_y;
    rsp_t               rsp_q;

    // the output register can take a new result whenever it is empty or draining
    assign can_issue = !rsp_valid || rsp_ready;

    // Round-robin scan starting at rr_ptr; suppressed in reset and under backpressure
    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!gnt_any && req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(j);
            end
        end
        if (rst || !can_issue) gnt_any = 1'b0;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    assign req_ready = gnt;
    assign add_a     = req_operand_a[int'(gnt_idx)*32 +: 32];
    assign add_b     = req_operand_b[int'(gnt_idx)*32 +: 32];

    fp_add u_fp_add (
        .a (add_a),
        .b (add_b),
        .y (add_y)
    );

    // Output register, round-robin pointer and drain counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            op_count  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
            if (gnt_any) begin
                rsp_valid <= 1'b1;
                rsp_q     <= '{result: add_y, id: gnt_idx};
                rr_ptr    <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_result = rsp_q.result;
    assign rsp_id     = rsp_q.id;
endmodule
